// File: rtl/line_clear.sv
// line_clear: removes full rows from the board RAM after a piece locks, shifting rows above down.
// Optional macro LINE_CLEAR_SCORE_EN adds a score_delta output derived from lines_cleared.
`default_nettype none

module line_clear #(
  parameter int COLS   = 10,
  parameter int ROWS   = 25,
  parameter int DATA_W = 6,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              wren,
  output logic [DATA_W-1:0] data,
  output logic              complete,
  output logic [4:0]        lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [7:0]        score_delta
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0]     LAST_COL = CW'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  typedef enum logic [2:0] {
    IDLE, CHK_A, CHK_D, CP_A, CP_D, CP_W, FILL, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     scan_row_q, scan_row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        lines_q, lines_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      scan_row_q <= '0;
      col_q      <= '0;
      data_q     <= '0;
      lines_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      scan_row_q <= scan_row_d;
      col_q      <= col_d;
      data_q     <= data_d;
      lines_q    <= lines_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_row_d = scan_row_q;
    col_d      = col_q;
    data_d     = data_q;
    lines_d    = lines_q;
    if (!enable) begin
      state_d    = IDLE;
      row_d      = '0;
      scan_row_d = '0;
      col_d      = '0;
      data_d     = '0;
      lines_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          row_d   = LAST_ROW;
          col_d   = '0;
          lines_d = '0;
          state_d = CHK_A;
        end
        CHK_A: state_d = CHK_D;
        CHK_D: begin
          if (ram_q == '0) begin
            if (row_q == '0) begin
              state_d = DONE;
            end else begin
              row_d   = row_q - RW'(1);
              col_d   = '0;
              state_d = CHK_A;
            end
          end else if (col_q == LAST_COL) begin
            if (lines_q != 5'd31) lines_d = lines_q + 5'd1;
            scan_row_d = row_q;
            col_d      = '0;
            state_d    = (row_q == '0) ? FILL : CP_A;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = CHK_A;
          end
        end
        CP_A: state_d = CP_D;
        CP_D: begin
          data_d  = ram_q;
          state_d = CP_W;
        end
        CP_W: begin
          if (col_q != LAST_COL) begin
            col_d   = col_q + CW'(1);
            state_d = CP_A;
          end else begin
            col_d      = '0;
            scan_row_d = scan_row_q - RW'(1);
            state_d    = (scan_row_q == RW'(1)) ? FILL : CP_A;
          end
        end
        FILL: begin
          // row stays put: the row above has dropped into it and must be re-checked
          if (col_q != LAST_COL) begin
            col_d = col_q + CW'(1);
          end else begin
            col_d   = '0;
            state_d = CHK_A;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr      = '0;
    wren          = 1'b0;
    data          = '0;
    complete      = 1'b0;
    lines_cleared = lines_q;
    case (state_q)
      CHK_A, CHK_D: ram_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
      CP_A, CP_D:   ram_addr = ADDR_W'(scan_row_q - RW'(1)) * COLS_A + ADDR_W'(col_q);
      CP_W: begin
        ram_addr = ADDR_W'(scan_row_q) * COLS_A + ADDR_W'(col_q);
        wren     = 1'b1;
        data     = data_q;
      end
      FILL: begin
        ram_addr = ADDR_W'(col_q);
        wren     = 1'b1;
      end
      DONE:    complete = 1'b1;
      default: ;
    endcase
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [7:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (!enable) begin
      score_d = '0;
    end else if (state_q != DONE && state_d == DONE) begin
      case (lines_q)
        5'd0:    score_d = 8'd0;
        5'd1:    score_d = 8'd1;
        5'd2:    score_d = 8'd3;
        5'd3:    score_d = 8'd5;
        default: score_d = 8'd8;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score_delta = score_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_clear.sv
// Randomized + directed bench for line_clear with a row-level reference model and a RAM model.
`default_nettype none

module tb_line_clear;
  localparam int C = 10;
  localparam int R = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic       wren;
  logic [5:0] data;
  logic       complete;
  logic [4:0] lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
  logic [7:0] score_delta;
`endif

  line_clear #(.COLS(C), .ROWS(R), .DATA_W(6), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ram_q(ram_q),
    .ram_addr(ram_addr), .wren(wren), .data(data), .complete(complete),
    .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
    , .score_delta(score_delta)
`endif
  );

  always #5 clk = ~clk;

  logic [5:0] mem   [0:255];
  logic [5:0] stage [0:255];
  int         exp_mem [0:255];
  logic       ld = 1'b0;

  // single-port synchronous RAM; ld copies a whole staged board in one cycle
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= stage[i];
    end else begin
      ram_q <= mem[ram_addr];
      if (wren) mem[ram_addr] <= data;
    end
  end

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  bit chk_writes = 0;
  int exp_a[$];
  int exp_d[$];
  int exp_score = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int score_of(input int l);
    case (l)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 8;
    endcase
  endfunction

  // Per-cycle checker: idle outputs after a reset/disabled edge, and every write against the model.
  logic en_s, rst_s;
  always @(posedge clk) begin
    en_s  = enable;
    rst_s = reset;
    #1;
    if (rst_s || !en_s) begin
      check("idle_outputs", {ram_addr, wren, data, complete, lines_cleared}, 0);
`ifdef LINE_CLEAR_SCORE_EN
      check("idle_score", score_delta, 0);
`endif
    end
    if (wren === 1'b1) begin
      wr_cnt++;
      if (chk_writes) begin
        if (exp_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected: got addr %0d data %0d expected no write", ram_addr, data);
        end else begin
          check("wr_addr", ram_addr, exp_a.pop_front());
          check("wr_data", data, exp_d.pop_front());
        end
      end
    end
  end

  // Row-level model: clear a full row by moving every row above down, blank row 0, re-check.
  task automatic build_model(output int lines);
    int b[R][C];
    int r;
    bit full;
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) b[y][x] = int'(mem[y*C+x]);
    exp_a.delete();
    exp_d.delete();
    lines = 0;
    r = R - 1;
    while (1) begin
      full = 1;
      for (int x = 0; x < C; x++) if (b[r][x] == 0) full = 0;
      if (full) begin
        if (lines < 31) lines++;
        for (int s = r; s >= 1; s--)
          for (int x = 0; x < C; x++) begin
            b[s][x] = b[s-1][x];
            exp_a.push_back(s*C + x);
            exp_d.push_back(b[s][x]);
          end
        for (int x = 0; x < C; x++) begin
          b[0][x] = 0;
          exp_a.push_back(x);
          exp_d.push_back(0);
        end
      end else if (r == 0) begin
        break;
      end else begin
        r--;
      end
    end
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) exp_mem[y*C+x] = b[y][x];
    exp_score = score_of(lines);
  endtask

  task automatic load_board();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic clear_stage();
    for (int i = 0; i < 256; i++) stage[i] = '0;
  endtask

  task automatic fill_row(input int r, input logic [5:0] v);
    for (int x = 0; x < C; x++) stage[r*C+x] = v;
  endtask

  task automatic run_pass(input string nm, input int rst_at, output int cyc,
                          output int lines, output int nwr);
    int  exp_lines;
    int  diffs;
    int  first;
    bit  done;
    @(negedge clk);
    build_model(exp_lines);
    wr_cnt     = 0;
    chk_writes = 1;
    enable     = 1'b1;
    cyc        = 0;
    done       = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      reset = (cyc == rst_at);
      if (complete === 1'b1) done = 1;
    end
    check({nm, "_complete"}, done, 1);
    lines = int'(lines_cleared);
    nwr   = wr_cnt;
    check({nm, "_lines"}, lines_cleared, exp_lines);
`ifdef LINE_CLEAR_SCORE_EN
    check({nm, "_score"}, score_delta, exp_score);
`endif
    check({nm, "_writes_left"}, exp_a.size(), 0);
    diffs = 0;
    first = -1;
    for (int i = 0; i < R*C; i++)
      if (int'(mem[i]) != exp_mem[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    if (diffs != 0) $display("first board difference at cell %0d", first);
    check({nm, "_board_diffs"}, diffs, 0);
    @(negedge clk);
    enable     = 1'b0;
    reset      = 1'b0;
    chk_writes = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, lines, nwr, zsum, nfull;
    bit full;
    clear_stage();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_complete", complete, 0);
    check("reset_lines", lines_cleared, 0);

    // empty board
    load_board();
    run_pass("empty", -1, cyc, lines, nwr);
    check("empty_latency_le52", (cyc <= 52), 1);
    check("empty_wren_count", nwr, 0);
    check("empty_lines_lit", lines, 0);

    // single full bottom row with one cell above
    clear_stage();
    fill_row(24, 6'h01);
    stage[233] = 6'h05;
    load_board();
    run_pass("one_row", -1, cyc, lines, nwr);
    check("one_row_cell243", mem[243], 5);
    zsum = 0;
    for (int x = 0; x < C; x++) zsum += int'(mem[23*C+x]) + int'(mem[x]);
    check("one_row_rows23_0_empty", zsum, 0);
    check("one_row_lines_lit", lines, 1);

    // two full rows separated by a partial row
    clear_stage();
    fill_row(24, 6'h11);
    fill_row(22, 6'h22);
    stage[230] = 6'h02;
    load_board();
    run_pass("two_rows", -1, cyc, lines, nwr);
    check("two_rows_cell240", mem[240], 2);
    zsum = 0;
    for (int i = 0; i < 240; i++) zsum += int'(mem[i]);
    check("two_rows_upper_empty", zsum, 0);
    check("two_rows_lines_lit", lines, 2);
`ifdef LINE_CLEAR_SCORE_EN
    check("two_rows_score_lit", exp_score, 3);
`endif

    // only the top row full
    clear_stage();
    fill_row(0, 6'h3F);
    load_board();
    run_pass("top_row", -1, cyc, lines, nwr);
    check("top_row_wren_count", nwr, 10);
    check("top_row_lines_lit", lines, 1);

    // abort during the first copy write
    clear_stage();
    fill_row(24, 6'h01);
    load_board();
    @(negedge clk);
    chk_writes = 0;
    enable = 1'b1;
    cyc = 0;
    while (wren !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reached_write", wren, 1);
    check("abort_first_addr", ram_addr, 240);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_wren", wren, 0);
    check("abort_complete", complete, 0);
    check("abort_addr", ram_addr, 0);
    check("abort_write_kept", mem[240], 0);
    run_pass("abort_rerun", -1, cyc, lines, nwr);
    check("abort_rerun_lines_lit", lines, 0);

    // reset pulse while the bottom row is still being checked
    clear_stage();
    fill_row(24, 6'h07);
    fill_row(20, 6'h09);
    stage[235] = 6'h04;
    load_board();
    run_pass("reset_mid", 6, cyc, lines, nwr);
    check("reset_mid_lines_lit", lines, 2);

    // randomized boards
    for (int k = 0; k < 12; k++) begin
      clear_stage();
      for (int y = 0; y < R; y++) begin
        for (int x = 0; x < C; x++)
          stage[y*C+x] = ($urandom_range(0, 9) < 6) ? 6'($urandom_range(1, 63)) : 6'd0;
        stage[y*C + $urandom_range(0, C-1)] = 6'd0;
      end
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
        int r = $urandom_range(0, R-1);
        for (int x = 0; x < C; x++) stage[r*C+x] = 6'($urandom_range(1, 63));
      end
      nfull = 0;
      for (int y = 0; y < R; y++) begin
        full = 1;
        for (int x = 0; x < C; x++) if (stage[y*C+x] == 0) full = 0;
        if (full) nfull++;
      end
      load_board();
      run_pass("rand", -1, cyc, lines, nwr);
      check("rand_lines_vs_count", lines, nfull);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_clear.md
Name: line_clear

Overview:
- Runs after each piece locks into the board RAM.
- Scans the playfield for fully occupied rows and removes each one by shifting every row above it down by one. The top row is refilled with empty cells.
- Shares the single-port board RAM (address/wren/data bus) with the board clear stage.
- Uses the same level-enable / complete handshake as the board clear stage, so the game controller can sequence both identically.

Parameters:
- COLS, 10, cells per row.
- ROWS, 25, rows on the board. Row 0 is the top row.
- DATA_W, 6, cell width. The value 0 means empty; any nonzero value means occupied.
- ADDR_W, 8, RAM address width. COLS*ROWS must be no greater than 2^ADDR_W.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level request. High runs one full clear pass; low aborts and returns to IDLE.
- ram_q  input  DATA_W  RAM read data, valid one cycle after ram_addr is presented.
- ram_addr  output  ADDR_W  cell address, equal to row*COLS+col.
- wren  output  1  RAM write strobe, asserted for exactly one cycle per write.
- data  output  DATA_W  RAM write data.
- complete  output  1  high once the pass is finished; held until enable falls.
- lines_cleared  output  5  number of rows removed in this pass; valid while complete is high.

Behaviour:
- Reset (and any cycle with enable low):
  - ram_addr=0, wren=0, data=0, complete=0.
  - lines_cleared=0, state=IDLE.
  - Dropping enable mid-pass aborts on the next edge. A write already issued is not retracted, so the board may be left partially shifted; the controller must re-run the pass.
- States: IDLE, CHK_A, CHK_D, CP_A, CP_D, CP_W, FILL, DONE. Internal counters are row, scan_row and col.
- IDLE: when enable is high, set row=ROWS-1, col=0, lines_cleared=0, then go to CHK_A.
- Row check:
  - CHK_A drives ram_addr=row*COLS+col, then goes to CHK_D.
  - CHK_D samples ram_q:
    - If ram_q==0 (row not full): if row==0 go to DONE; otherwise row=row-1, col=0, go to CHK_A.
    - Else if col==COLS-1 (row full): lines_cleared++ (saturating at 31), set scan_row=row and col=0. If row==0 go to FILL, otherwise go to CP_A.
    - Else col++ and go to CHK_A.
- Copy loop (moves row scan_row-1 into row scan_row):
  - CP_A drives ram_addr=(scan_row-1)*COLS+col.
  - CP_D latches ram_q into data.
  - CP_W drives ram_addr=scan_row*COLS+col with wren=1.
  - After CP_W: if col<COLS-1, col++ and go to CP_A. Otherwise col=0 and scan_row--; if scan_row==0 go to FILL, else go to CP_A.
- FILL: writes data=0 with wren=1 to addresses 0..COLS-1, one per cycle. Then col=0 and row is left unchanged, so the same row is re-checked because new content has dropped into it. Go to CHK_A.
- DONE: complete=1, wren=0, ram_addr=0. Stay in DONE until enable falls.
- wren is high only in CP_W and FILL cycles. data is forced to 0 in FILL.
- Cycle budget:
  - Empty board: each row exits after its first cell, so complete rises within 2*ROWS+2 cycles of enable.
  - Each cleared row at index r costs at most 2*COLS (check) + 3*COLS*r (copy) + COLS (fill) cycles.
- Address arithmetic is done at ADDR_W width. row*COLS never exceeds COLS*ROWS-1, so no wrap occurs.
- reset has priority over enable.

Optional Feature:
- Macro LINE_CLEAR_SCORE_EN.
- Defined:
  - Adds output score_delta [7:0].
  - Set on entry to DONE from lines_cleared: 0→0, 1→1, 2→3, 3→5, 4 or more→8.
  - Held while complete is high; cleared by reset or by enable going low.
- Undefined: the port is absent and no scoring logic is generated. All other behaviour is identical.

Test Plan:
- All-zero board, enable=1 → no wren pulses; complete=1 within 52 cycles; lines_cleared=0.
- Row 24 all 1s, row 23 col3=6'h05, everything else 0 → after the pass: cell 243=6'h05, row 23 all 0, row 0 all 0, lines_cleared=1.
- Rows 24 and 22 full, row 23 col0=6'h02 → after the pass: cell 240=6'h02, rows 0–23 empty, lines_cleared=2. With LINE_CLEAR_SCORE_EN defined, score_delta=3.
- Only row 0 full (all 6'h3F) → exactly 10 wren pulses at addresses 0..9 with data=0; lines_cleared=1; complete=1.
- Row 24 full, enable dropped during the first CP_W → next cycle wren=0, complete=0, ram_addr=0. Re-asserting enable restarts with lines_cleared=0.
- reset asserted for 1 cycle mid-pass with enable still high → all outputs 0 that cycle. The pass then restarts from row 24 and completes correctly.
